// File: rtl/store_pkg.sv
// Shared definitions for the store merge unit: request size encodings,
// control state enumeration and the read-latency counter width.
package store_pkg;

  // Request size field encodings (11 is reserved and always rejected).
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Wide enough to count a read latency of up to 7 cycles.
  localparam int unsigned CNT_W = 3;

endpackage : store_pkg

// File: rtl/store_merge_unit_if.sv
// Pipeline-side store request handshake.
//   master (MEM stage): drives req_valid/req_addr/req_size/req_wdata,
//                       observes req_ready/done/misalign.
//   slave  (store unit): the reverse.
interface store_merge_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_wdata;
  logic              done;
  logic              misalign;

  modport master (
    output req_valid, req_addr, req_size, req_wdata,
    input  req_ready, done, misalign
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_wdata,
    output req_ready, done, misalign
  );

endinterface : store_merge_unit_if

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge for stores (little-endian lanes).
//   old_i    : word the untouched lanes are taken from
//   data_i   : store data, low bits used for byte/half
//   off_i    : byte offset addr[1:0]
//   size_i   : request size encoding
//   merged_o : old_i with the selected lane(s) replaced by the store data
//   mask_o   : selected lanes; all-zero marks a misaligned/reserved request
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  output logic [31:0] merged_o,
  output logic [3:0]  mask_o
);

  logic [31:0] repl;

  // Lane selection; illegal alignments yield an empty mask.
  always_comb begin
    mask_o = 4'b0000;
    repl   = data_i;
    case (size_i)
      SZ_BYTE: begin
        mask_o = 4'(4'b0001 << off_i);
        repl   = {4{data_i[7:0]}};
      end
      SZ_HALF: begin
        if (!off_i[0]) mask_o = off_i[1] ? 4'b1100 : 4'b0011;
        repl = {2{data_i[15:0]}};
      end
      SZ_WORD: begin
        if (off_i == 2'b00) mask_o = 4'b1111;
      end
      default: mask_o = 4'b0000;
    endcase
  end

  // Replicated data lands in every lane; the mask picks which lanes keep it.
  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (mask_o[i]) merged_o[8*i +: 8] = repl[8*i +: 8];
    end
  end

endmodule : store_lane_merge

// File: rtl/store_merge_unit.sv
// Store merge unit: places SB/SH/SW data into the correct byte lanes of a
// word-addressed data memory. Sub-word stores use read-modify-write unless
// STORE_BYTE_MASK_EN is defined, in which case they write directly with a
// byte-enable mask (extra output mem_be).
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request handshake (slave modport)
//   mem_addr   : word address, held from accept until back in IDLE
//   mem_rd_en  : one-cycle read strobe; mem_rdata valid RD_LAT cycles later
//   mem_wr_en  : one-cycle write strobe with mem_wdata (and mem_be)
module store_merge_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  store_merge_unit_if.slave req,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata
`ifdef STORE_BYTE_MASK_EN
  ,
  output logic [3:0]        mem_be
`endif
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic [31:0]       data_q;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wdata_q;
  logic              ready_q, done_q, mis_q, rd_q, wr_q;
`ifdef STORE_BYTE_MASK_EN
  logic [3:0]        be_q;
`endif

  logic              idle_c, direct_c;
  logic [31:0]       old_c, dat_c, merged_c;
  logic [1:0]        off_c, siz_c;
  logic [3:0]        mask_c;

  // In IDLE the merger looks at the live request (alignment check and
  // direct writes); in READ it merges latched data into the returned word.
  assign idle_c = (state_q == IDLE);
  assign old_c  = idle_c ? 32'h0 : mem_rdata;
  assign dat_c  = idle_c ? req.req_wdata : data_q;
  assign off_c  = idle_c ? req.req_addr[1:0] : off_q;
  assign siz_c  = idle_c ? req.req_size : size_q;

`ifdef STORE_BYTE_MASK_EN
  assign direct_c = 1'b1;
`else
  assign direct_c = (req.req_size == SZ_WORD);
`endif

  store_lane_merge u_merge (
    .old_i    (old_c),
    .data_i   (dat_c),
    .off_i    (off_c),
    .size_i   (siz_c),
    .merged_o (merged_c),
    .mask_o   (mask_c)
  );

  // Control FSM with registered outputs; strobes default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      data_q  <= 32'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef STORE_BYTE_MASK_EN
      be_q    <= 4'b0000;
`endif
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req.req_valid && ready_q) begin
            ready_q <= 1'b0;
            addr_q  <= req.req_addr[ADDR_W-1:2];
            off_q   <= req.req_addr[1:0];
            size_q  <= req.req_size;
            data_q  <= req.req_wdata;
            if (mask_c == 4'b0000) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else if (direct_c) begin
              state_q <= WRITE;
              wr_q    <= 1'b1;
              wdata_q <= merged_c;
`ifdef STORE_BYTE_MASK_EN
              be_q    <= mask_c;
`endif
            end else begin
              state_q <= READ;
              rd_q    <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        READ: begin
          // Count starts at 0 in the strobe cycle; data is valid at RD_LAT.
          if (cnt_q == CNT_W'(RD_LAT)) begin
            state_q <= WRITE;
            wr_q    <= 1'b1;
            wdata_q <= merged_c;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WRITE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign req.done      = done_q;
  assign req.misalign  = mis_q;
  assign mem_addr      = addr_q;
  assign mem_rd_en     = rd_q;
  assign mem_wr_en     = wr_q;
  assign mem_wdata     = wdata_q;
`ifdef STORE_BYTE_MASK_EN
  assign mem_be        = be_q;
`endif

endmodule : store_merge_unit

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: directed stores from the test
// plan, a mid-operation reset and a randomized phase, all checked every
// cycle against a request-level model with a reference word memory.
module tb_store_merge_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RD_LAT = 1;
`ifdef STORE_BYTE_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_merge_unit_if #(.ADDR_W(ADDR_W)) bus ();

  logic [ADDR_W-3:0] mem_addr;
  logic              mem_rd_en, mem_wr_en;
  logic [31:0]       mem_rdata, mem_wdata;
`ifdef STORE_BYTE_MASK_EN
  logic [3:0]        mem_be;
`endif

  store_merge_unit #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.slave),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
`ifdef STORE_BYTE_MASK_EN
    .mem_be    (mem_be),
`endif
    .mem_wdata (mem_wdata)
  );

  // Model state: one outstanding request described by kind and latency.
  // kind 0 = rejected, 1 = direct write, 2 = read-modify-write.
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, a = 0, kind = 0, lat = 1;
  bit          busy = 1'b0, accepted = 1'b0;
  int          widx = 0;
  logic [29:0] exp_addr;
  logic [31:0] exp_wd, exp_full;
  logic [3:0]  exp_be;
  logic [31:0] mem [16];
  logic [31:0] last_wd;
  logic [29:0] last_wa;
  logic [3:0]  last_be;
  int          last_done_d, last_mis, wr_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%08h want=%08h", nm, cyc, act, exp);
    end
  endtask

  // Request-level reference: decides acceptance and precomputes the write.
  task automatic model_edge();
    int o, nb;
    logic [1:0] sz;
    cyc++;
    accepted = 1'b0;
    if (!rst_n) begin
      busy = 1'b0;
      return;
    end
    if (busy && (cyc - a) >= lat + 1) busy = 1'b0;
    if (!busy && bus.req_valid) begin
      o  = int'(bus.req_addr[1:0]);
      sz = bus.req_size;
      nb = (sz == 2'd3) ? 0 : (1 << sz);
      widx     = int'(bus.req_addr[5:2]);
      exp_addr = bus.req_addr[31:2];
      exp_full = mem[widx];
      exp_wd   = MASK ? 32'h0 : mem[widx];
      exp_be   = 4'b0000;
      if (nb == 0 || (o % nb) != 0) begin
        kind = 0;
        lat  = 1;
      end else begin
        kind = (nb == 4 || MASK) ? 1 : 2;
        lat  = (kind == 1) ? 2 : int'(RD_LAT) + 3;
        for (int k = 0; k < nb; k++) begin
          exp_full[8*(o+k) +: 8] = bus.req_wdata[8*k +: 8];
          exp_wd[8*(o+k) +: 8]   = bus.req_wdata[8*k +: 8];
          exp_be[o+k]            = 1'b1;
        end
      end
      busy     = 1'b1;
      accepted = 1'b1;
      a        = cyc;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic check_cycle();
    int d;
    bit b;
    d = cyc - a + 1;
    b = busy && (d <= lat);
    chk("req_ready", 32'(bus.req_ready), 32'(!b));
    chk("done", 32'(bus.done), 32'(b && d == lat));
    chk("misalign", 32'(bus.misalign), 32'(b && d == lat && kind == 0));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(b && kind == 2 && d == 1));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(b && kind != 0 && d == lat - 1));
    if (b) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (b && kind != 0 && d == lat - 1) begin
      chk("mem_wdata", mem_wdata, exp_wd);
`ifdef STORE_BYTE_MASK_EN
      chk("mem_be", 32'(mem_be), 32'(exp_be));
`endif
      mem[widx] = exp_full;
    end
    if (mem_wr_en) begin
      last_wd = mem_wdata;
      last_wa = mem_addr;
`ifdef STORE_BYTE_MASK_EN
      last_be = mem_be;
`endif
      wr_count++;
    end
    if (bus.done) begin
      last_done_d = d;
      last_mis    = int'(bus.misalign);
    end
    // Read data is only meaningful in the cycle the model says it returns.
    if (b && kind == 2 && d == int'(RD_LAT) + 1) mem_rdata = mem[widx];
    else                                        mem_rdata = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_mis"}, 32'(bus.misalign), 32'd0);
    chk({tag, "_rd"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_wr"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
`ifdef STORE_BYTE_MASK_EN
    chk({tag, "_be"}, 32'(mem_be), 32'd0);
`endif
  endtask

  // Drive one request from idle and run until the unit is idle again.
  task automatic send(input logic [31:0] ad, input logic [1:0] sz, input logic [31:0] dt);
    int t;
    bus.req_valid = 1'b1;
    bus.req_addr  = ad;
    bus.req_size  = sz;
    bus.req_wdata = dt;
    last_done_d   = -1;
    last_mis      = -1;
    t = 0;
    do begin
      step();
      t++;
    end while (!accepted && t < 20);
    bus.req_valid = 1'b0;
    n_cmp++;
    if (!accepted) begin
      n_err++;
      $display("FAIL accept_timeout cyc=%0d got=no_accept want=accept", cyc);
    end else begin
      repeat (lat) step();
    end
  endtask

  int wc0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = 2'b00;
    bus.req_wdata = 32'h0;
    mem_rdata     = 32'h0;
    wr_count      = 0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst0");
    rst_n = 1'b1;
    step();

    // Word store.
    send(32'h0000_0100, 2'b10, 32'hDEAD_BEEF);
    chk("sw_wdata", last_wd, 32'hDEAD_BEEF);
    chk("sw_waddr", 32'(last_wa), 32'h40);
    chk("sw_done_lat", 32'(last_done_d), 32'd2);

    // Byte store into a known word.
    mem[0] = 32'h1122_3344;
    send(32'h0000_0102, 2'b00, 32'h0000_00AA);
`ifdef STORE_BYTE_MASK_EN
    chk("sb_wdata", last_wd, 32'h00AA_0000);
    chk("sb_done_lat", 32'(last_done_d), 32'd2);
`else
    chk("sb_wdata", last_wd, 32'h11AA_3344);
    chk("sb_done_lat", 32'(last_done_d), 32'd4);
`endif

    // Upper halfword store.
    mem[1] = 32'h1122_3344;
    send(32'h0000_0106, 2'b01, 32'h0000_CAFE);
`ifdef STORE_BYTE_MASK_EN
    chk("sh_wdata", last_wd, 32'hCAFE_0000);
    chk("sh_be", 32'(last_be), 32'hC);
`else
    chk("sh_wdata", last_wd, 32'hCAFE_3344);
`endif
    chk("sh_waddr", 32'(last_wa), 32'h41);

    // Misaligned halfword: rejected with no memory traffic.
    wc0 = wr_count;
    send(32'h0000_0103, 2'b01, 32'h0000_1234);
    chk("mis_done_lat", 32'(last_done_d), 32'd1);
    chk("mis_flag", 32'(last_mis), 32'd1);
    chk("mis_no_write", 32'(wr_count - wc0), 32'd0);

`ifdef STORE_BYTE_MASK_EN
    send(32'h0000_0101, 2'b00, 32'h0000_0055);
    chk("sbm_wdata", last_wd, 32'h0000_5500);
    chk("sbm_be", 32'(last_be), 32'h2);
    chk("sbm_done_lat", 32'(last_done_d), 32'd2);
`endif

    // Reset during an in-flight byte store.
    wc0 = wr_count;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_010A;
    bus.req_size  = 2'b00;
    bus.req_wdata = $urandom;
    step();
    bus.req_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1 busy = 1'b0;
    check_reset_vals("rst_mid");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_no_write", 32'(wr_count - wc0), 32'd0);
    send(32'h0000_0110, 2'b10, 32'h0BAD_F00D);
    chk("post_rst_wdata", last_wd, 32'h0BAD_F00D);
    chk("post_rst_lat", 32'(last_done_d), 32'd2);

    // Randomized traffic; valid is freely asserted while busy.
    for (int n = 0; n < 800; n++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_addr  = 32'h0000_0100 + 32'($urandom_range(0, 63));
      bus.req_size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      bus.req_wdata = $urandom;
      step();
    end
    bus.req_valid = 1'b0;
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_store_merge_unit

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Write-side counterpart of the load-path sign/zero extension. Narrows SB/SH/SW store data into the correct byte lanes of a 32-bit word-addressed data memory.
- Default build performs read-modify-write for sub-word stores.
- Sits between the MEM pipeline stage and data memory. Stalls the pipeline through a valid/ready handshake until the store has committed.

Parameters:
- ADDR_W, 32: byte-address width.
- RD_LAT, 1: data-memory read latency in cycles (1..7); mem_rdata is valid RD_LAT cycles after mem_rd_en.

Ports:
- Clk  in  1  clock; all logic updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_wdata  in  32  store data; low bits are used for byte/half.
- done  out  1  one-cycle pulse; the store has committed or has been rejected.
- misalign  out  1  valid with done; the request was rejected.
- mem_addr  out  ADDR_W-2  word address (req_addr[ADDR_W-1:2]).
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rdata  in  32  read data.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wdata  out  32  merged write word.

Behaviour:
- Reset values:
  - State is IDLE.
  - req_ready=1.
  - done, misalign, mem_rd_en and mem_wr_en are 0.
  - mem_addr and mem_wdata are 0.
- Request acceptance: a request is accepted when req_valid && req_ready. addr, size and data are latched on acceptance.
- Lanes are little-endian: addr[1:0]=0 selects bits 7:0, 1 selects 15:8, 2 selects 23:16, 3 selects 31:24. A halfword at addr[1]=0 selects bits 15:0; at addr[1]=1 it selects bits 31:16.
- Misaligned requests: a halfword with addr[0]=1, a word with addr[1:0]!=0, or size=11.
  - Next state is DONE with misalign=1.
  - No memory strobe is issued.
- States:
  - IDLE: on accept, go to WRITE (word), READ (byte/half) or DONE (misaligned).
  - READ: pulse mem_rd_en for 1 cycle, then count RD_LAT cycles. In the cycle the count expires, capture mem_rdata and go to WRITE.
  - WRITE:
    - mem_wr_en=1 for exactly one cycle.
    - For a word store, mem_wdata = latched data.
    - For a byte/half store, mem_wdata = captured word with the selected lane(s) replaced by data[7:0] or data[15:0]; all other lanes are unchanged.
    - Next state is DONE.
  - DONE: done=1 for one cycle; req_ready=0; next state is IDLE.
- Latency from accept to done:
  - word store: 2 cycles;
  - byte/half store: RD_LAT+3 cycles;
  - misaligned request: 1 cycle.
- Throughput: one request at a time. req_ready is 0 in every state except IDLE. A req_valid held during a busy period is ignored; it is not queued.
- mem_addr is held stable from acceptance until return to IDLE.
- Rst asserted mid-operation aborts the operation immediately, with no write. If the abort lands in the WRITE cycle, the write strobe is deasserted asynchronously.
- Only the selected lanes differ between the captured word and mem_wdata.

Optional Feature:
- Macro: STORE_BYTE_MASK_EN.
- When defined:
  - Adds output port mem_be (4 bits; reset value 0).
  - Byte/half stores skip READ and go straight to WRITE.
  - mem_wdata carries the data replicated into the selected lane(s); all other lanes are 0.
  - mem_be marks the selected lane(s). mem_be=1111 for word stores.
  - Sub-word latency from accept to done drops to 2 cycles.
- When undefined: read-modify-write behaviour as above, and no mem_be port.

Decomposition:
- Shared package store_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state enumeration (IDLE/READ/WRITE/DONE);
  - the RD_LAT counter width constant (3 bits).
- One sub-module, store_lane_merge: purely combinational.
  - Inputs: old word, data, addr[1:0], size.
  - Outputs: merged word and 4-bit lane mask.
  - It is reused for both build variants.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF → mem_wr_en at cycle +1; mem_addr=0x40; mem_wdata=0xDEADBEEF; no mem_rd_en; done at cycle +2.
- SB addr 0x102, data 0x000000AA, old word 0x11223344, RD_LAT=1 → one mem_rd_en, then a write of 0x11AA3344; done at accept+4.
- SH addr 0x106, data 0x0000CAFE, old word 0x11223344 → write 0xCAFE3344 to word address 0x41.
- SH addr 0x103 → done and misalign high in the same cycle; no mem_rd_en or mem_wr_en; req_ready returns next cycle.
- Rst low during the READ wait of an SB → all outputs return to reset values asynchronously; no mem_wr_en ever issues; a new SW after reset completes normally.
- STORE_BYTE_MASK_EN defined, SB addr 0x101, data 0x55 → mem_be=0010, mem_wdata=0x00005500, no read, done at accept+2.
